// File: rtl/boot_loader.sv
// -----------------------------------------------------------------------------
// boot_loader
//
// Receives a boot image over a byte stream, writes it word by word into
// memory starting at BASE_ADDR, then releases the CPU from reset and hands
// the memory port over to it.
//
// Frame: 0xA5, count N (16-bit little-endian), 4N payload bytes (each word
// little-endian), then an XOR checksum byte when LOADER_CHECKSUM_EN is
// defined. Without the macro the checksum byte, the CHECK state and the
// checksum register are not built.
//
// Parameters
//   MAX_WORDS     largest accepted image size in 32-bit words
//   BASE_ADDR     memory address of image word 0
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   rx_valid      byte-stream valid
//   rx_data       byte-stream data
//   rx_ready      byte accepted when rx_valid && rx_ready at a clk edge
//   cpu_adres     CPU memory address      (routed to memory only in RUN)
//   cpu_yaz_veri  CPU write data          (routed to memory only in RUN)
//   cpu_yaz       CPU write strobe        (routed to memory only in RUN)
//   cpu_rst       reset to the CPU, low only in RUN
//   mem_adres     memory address
//   mem_yaz_veri  memory write data
//   mem_yaz       memory write strobe
//   load_done     image loaded, CPU running
//   err           protocol / length / checksum error
// -----------------------------------------------------------------------------
module boot_loader #(
   parameter int unsigned MAX_WORDS = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   input  logic [31:0] cpu_adres,
   input  logic [31:0] cpu_yaz_veri,
   input  logic        cpu_yaz,
   output logic        cpu_rst,
   output logic [31:0] mem_adres,
   output logic [31:0] mem_yaz_veri,
   output logic        mem_yaz,
   output logic        load_done,
   output logic        err
);

   typedef enum logic [2:0] {
      IDLE, LEN0, LEN1, DATA, WRITE, RUN, ERROR
`ifdef LOADER_CHECKSUM_EN
      , CHECK
`endif
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;         // image length N
   logic [15:0] idx_q, idx_d;         // index of the next word to write
   logic [1:0]  bcnt_q, bcnt_d;       // byte position inside the current word
   logic [31:0] word_q, word_d;       // word being assembled
   logic [31:0] adr_q, adr_d;         // loader-side memory address
   logic [31:0] wdat_q, wdat_d;       // loader-side memory write data
`ifdef LOADER_CHECKSUM_EN
   logic [7:0]  chk_q, chk_d;         // running XOR of payload bytes
`endif

   // Output flags are registered; they are decoded from the next state so
   // they line up with state_q.
   logic rx_ready_q, mem_yaz_q, cpu_rst_q, load_done_q, err_q;

   logic        accept;
   logic [15:0] len_rx;

   assign accept = rx_valid && rx_ready_q;
   assign len_rx = {rx_data, cnt_q[7:0]};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      bcnt_d  = bcnt_q;
      word_d  = word_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
`ifdef LOADER_CHECKSUM_EN
      chk_d   = chk_q;
`endif
      case (state_q)
         IDLE, ERROR: begin
            // Only a sync byte starts a frame; everything else is dropped.
            if (accept && rx_data == 8'hA5) begin
               state_d = LEN0;
               idx_d   = '0;
               bcnt_d  = '0;
`ifdef LOADER_CHECKSUM_EN
               chk_d   = '0;
`endif
            end
         end
         LEN0: begin
            if (accept) begin
               cnt_d[7:0] = rx_data;
               state_d    = LEN1;
            end
         end
         LEN1: begin
            if (accept) begin
               cnt_d[15:8] = rx_data;
               if (len_rx == 16'd0 || {16'd0, len_rx} > MAX_WORDS)
                  state_d = ERROR;
               else
                  state_d = DATA;
            end
         end
         DATA: begin
            if (accept) begin
               // Shift in from the top so byte 0 ends up in bits [7:0].
               word_d = {rx_data, word_q[31:8]};
               bcnt_d = bcnt_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
               chk_d  = chk_q ^ rx_data;
`endif
               if (bcnt_q == 2'd3) begin
                  // Address and data are loaded here so they are already
                  // on the memory port during the WRITE cycle.
                  adr_d   = BASE_ADDR + {14'd0, idx_q, 2'b00};
                  wdat_d  = word_d;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            idx_d = idx_q + 16'd1;
            if (idx_d == cnt_q)
`ifdef LOADER_CHECKSUM_EN
               state_d = CHECK;
`else
               state_d = RUN;
`endif
            else
               state_d = DATA;
         end
`ifdef LOADER_CHECKSUM_EN
         CHECK: begin
            if (accept)
               state_d = (rx_data == chk_q) ? RUN : ERROR;
         end
`endif
         RUN: begin
            // Terminal until reset.
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         idx_q       <= '0;
         bcnt_q      <= '0;
         word_q      <= '0;
         adr_q       <= '0;
         wdat_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= '0;
`endif
         rx_ready_q  <= 1'b1;
         mem_yaz_q   <= 1'b0;
         cpu_rst_q   <= 1'b1;
         load_done_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         bcnt_q      <= bcnt_d;
         word_q      <= word_d;
         adr_q       <= adr_d;
         wdat_q      <= wdat_d;
`ifdef LOADER_CHECKSUM_EN
         chk_q       <= chk_d;
`endif
         rx_ready_q  <= !(state_d == WRITE || state_d == RUN);
         mem_yaz_q   <= (state_d == WRITE);
         cpu_rst_q   <= (state_d != RUN);
         load_done_q <= (state_d == RUN);
         err_q       <= (state_d == ERROR);
      end
   end

   // In RUN the CPU owns the memory port combinationally.
   assign mem_adres    = load_done_q ? cpu_adres    : adr_q;
   assign mem_yaz_veri = load_done_q ? cpu_yaz_veri : wdat_q;
   assign mem_yaz      = load_done_q ? cpu_yaz      : mem_yaz_q;
   assign rx_ready     = rx_ready_q;
   assign cpu_rst      = cpu_rst_q;
   assign load_done    = load_done_q;
   assign err          = err_q;

endmodule

// File: tb/tb_boot_loader.sv
// -----------------------------------------------------------------------------
// tb_boot_loader
//
// Frames are built from a list of words; every write the image should cause
// is queued as the byte completing that word is sent. A monitor pops and
// compares whenever the loader strobes mem_yaz, and checks rx_ready and the
// held memory address/data on every other loading cycle. Frame outcome
// (RUN or ERROR) is predicted from the count range and checksum rules.
// Build with +define+LOADER_CHECKSUM_EN to exercise the checksum variant.
// -----------------------------------------------------------------------------
module tb_boot_loader;
   localparam int unsigned MAXW = 1024;
   localparam logic [31:0] BASE = 32'h8000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rx_ready;
   logic [31:0] cpu_adres;
   logic [31:0] cpu_yaz_veri;
   logic        cpu_yaz;
   logic        cpu_rst;
   logic [31:0] mem_adres;
   logic [31:0] mem_yaz_veri;
   logic        mem_yaz;
   logic        load_done;
   logic        err;

   boot_loader #(.MAX_WORDS(MAXW), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .cpu_adres(cpu_adres), .cpu_yaz_veri(cpu_yaz_veri), .cpu_yaz(cpu_yaz),
      .cpu_rst(cpu_rst),
      .mem_adres(mem_adres), .mem_yaz_veri(mem_yaz_veri), .mem_yaz(mem_yaz),
      .load_done(load_done), .err(err)
   );

   always #5 clk = ~clk;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];          // {address, data} of expected writes
   logic [31:0] last_adr = '0;
   logic [31:0] last_dat = '0;
   bit          mon_en = 1'b0;
   int          gap_mode = 0;      // 0: back-to-back, 1: every other cycle, 2: random

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: samples 1 time unit after the falling edge.
   initial begin
      logic [63:0] e;
      forever begin
         @(negedge clk);
         #1;
         if (mon_en && !rst && !load_done) begin
            if (mem_yaz) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h required no write",
                           mem_adres, mem_yaz_veri);
               end else begin
                  e = exp_q.pop_front();
                  check("write_addr", mem_adres, e[63:32]);
                  check("write_data", mem_yaz_veri, e[31:0]);
                  last_adr = e[63:32];
                  last_dat = e[31:0];
               end
               check("rx_ready_in_write", 32'(rx_ready), 32'd0);
            end else begin
               check("rx_ready_loading", 32'(rx_ready), 32'd1);
               check("hold_addr", mem_adres, last_adr);
               check("hold_data", mem_yaz_veri, last_dat);
            end
         end
      end
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Called at a falling edge; returns at the falling edge after acceptance.
   task automatic send_byte(input logic [7:0] b);
      int guard;
      if (gap_mode == 1) begin
         rx_valid = 1'b0;
         rx_data  = 8'($urandom);
         @(negedge clk);
      end else if (gap_mode == 2 && $urandom_range(0, 3) == 0) begin
         rx_valid = 1'b0;
         repeat ($urandom_range(1, 3)) @(negedge clk);
      end
      // CPU inputs are scrambled during loading; they must have no effect.
      cpu_yaz      = 1'($urandom);
      cpu_adres    = $urandom;
      cpu_yaz_veri = $urandom;
      rx_valid     = 1'b1;
      rx_data      = b;
      guard        = 0;
      while (!rx_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!rx_ready) begin
         checks++;
         errors++;
         $display("FAIL rx_ready_timeout: got rx_ready 0 for %0d cycles required 1", guard);
      end
      @(negedge clk);
      rx_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [15:0] n, input logic [31:0] words[$],
                             input bit bad_chk, input string tag);
      logic [7:0]  x;
      logic [31:0] w;
      logic [7:0]  b;
      bit          ok;
      x  = 8'h00;
      ok = (n != 16'd0) && ({16'd0, n} <= MAXW);
      send_byte(8'hA5);
      send_byte(n[7:0]);
      send_byte(n[15:8]);
      if (ok) begin
         for (int i = 0; i < int'(n); i++) begin
            w = words[i];
            for (int k = 0; k < 4; k++) begin
               b = w[8*k +: 8];
               x = x ^ b;
               if (k == 3)
                  exp_q.push_back({BASE + 32'(4 * i), w});
               send_byte(b);
            end
         end
`ifdef LOADER_CHECKSUM_EN
         send_byte(bad_chk ? (x ^ 8'h01) : x);
`endif
      end
      $display("frame %s: N=%0d checksum 0x%02h bad_chk=%0d gap_mode=%0d", tag, n, x, bad_chk, gap_mode);
   endtask

   task automatic expect_state(input bit run, input bit e, input string tag);
      repeat (3) @(negedge clk);
      check({tag, "_load_done"}, 32'(load_done), 32'(run));
      check({tag, "_cpu_rst"}, 32'(cpu_rst), 32'(!run));
      check({tag, "_err"}, 32'(err), 32'(e));
      check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst      = 1'b1;
      rx_valid = 1'b0;
      cpu_yaz  = 1'b0;
      @(negedge clk);
      exp_q.delete();
      last_adr = '0;
      last_dat = '0;
      rst      = 1'b0;
   endtask

   initial begin
      logic [31:0] wq[$];
      logic [31:0] w;
      logic [31:0] ra;
      int          n;
      bit          bad;

      rst = 1'b1; rx_valid = 1'b0; rx_data = '0;
      cpu_adres = '0; cpu_yaz_veri = '0; cpu_yaz = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("rst_mem_yaz", 32'(mem_yaz), 32'd0);
      check("rst_load_done", 32'(load_done), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_rx_ready", 32'(rx_ready), 32'd1);
      check("rst_mem_adres", mem_adres, 32'd0);
      check("rst_mem_yaz_veri", mem_yaz_veri, 32'd0);
      rst    = 1'b0;
      mon_en = 1'b1;

      // Single-word image, then CPU pass-through and reset out of RUN.
      wq = {32'h0010_0513};
      send_frame(16'd1, wq, 1'b0, "single");
      expect_state(1'b1, 1'b0, "single");
      @(negedge clk);
      cpu_adres = 32'h8000_0010; cpu_yaz = 1'b1; cpu_yaz_veri = 32'hDEAD_BEEF;
      rx_valid = 1'b1; rx_data = 8'hA5;
      #1;
      check("run_mem_adres", mem_adres, 32'h8000_0010);
      check("run_mem_yaz_veri", mem_yaz_veri, 32'hDEAD_BEEF);
      check("run_mem_yaz", 32'(mem_yaz), 32'd1);
      check("run_rx_ready", 32'(rx_ready), 32'd0);
      @(negedge clk);
      ra = $urandom;
      cpu_adres = ra; cpu_yaz = 1'b0;
      #1;
      check("run_mem_adres2", mem_adres, ra);
      check("run_mem_yaz2", 32'(mem_yaz), 32'd0);
      repeat (4) @(negedge clk);
      rx_valid = 1'b0;
      check("run_persists", 32'(load_done), 32'd1);
      do_reset();
      check("after_rst_cpu_rst", 32'(cpu_rst), 32'd1);
      check("after_rst_load_done", 32'(load_done), 32'd0);
      check("after_rst_rx_ready", 32'(rx_ready), 32'd1);
      check("after_rst_err", 32'(err), 32'd0);

      // Two words with rx_valid toggling every other cycle.
      gap_mode = 1;
      wq = {32'h1122_3344, 32'hAABB_CCDD};
      send_frame(16'd2, wq, 1'b0, "two_toggle");
      expect_state(1'b1, 1'b0, "two_toggle");
      do_reset();
      gap_mode = 0;

      // Leading garbage.
      send_byte(8'h00);
      send_byte(8'hFF);
      wq = {32'h0010_0513};
      send_frame(16'd1, wq, 1'b0, "garbage");
      expect_state(1'b1, 1'b0, "garbage");
      do_reset();

      // Length errors, then recovery.
      wq.delete();
      send_frame(16'd0, wq, 1'b0, "len_zero");
      expect_state(1'b0, 1'b1, "len_zero");
      send_frame(16'(MAXW + 1), wq, 1'b0, "len_over");
      expect_state(1'b0, 1'b1, "len_over");
      wq = {32'hA5A5_00A5};
      send_frame(16'd1, wq, 1'b0, "recover");
      expect_state(1'b1, 1'b0, "recover");
      do_reset();

`ifdef LOADER_CHECKSUM_EN
      wq = {32'h0010_0513};
      send_frame(16'd1, wq, 1'b1, "bad_checksum");
      expect_state(1'b0, 1'b1, "bad_checksum");
      do_reset();
`endif

      // Reset in the middle of a frame: one word written, then abandoned.
      send_byte(8'hA5); send_byte(8'h02); send_byte(8'h00);
      exp_q.push_back({BASE, 32'h0403_0201});
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06);
      expect_state(1'b0, 1'b0, "abort");
      do_reset();
      wq = {32'hCAFE_F00D, 32'h0BAD_BEEF};
      send_frame(16'd2, wq, 1'b0, "after_abort");
      expect_state(1'b1, 1'b0, "after_abort");
      do_reset();

      // Largest accepted image.
      wq.delete();
      for (int i = 0; i < int'(MAXW); i++) wq.push_back($urandom);
      send_frame(16'(MAXW), wq, 1'b0, "max_words");
      expect_state(1'b1, 1'b0, "max_words");
      do_reset();

      // Random frames with random stalls and embedded sync bytes.
      gap_mode = 2;
      for (int f = 0; f < 8; f++) begin
         n = $urandom_range(1, 6);
         wq.delete();
         for (int i = 0; i < n; i++) begin
            w = $urandom;
            if ($urandom_range(0, 2) == 0) w[15:8] = 8'hA5;
            wq.push_back(w);
         end
`ifdef LOADER_CHECKSUM_EN
         bad = ($urandom_range(0, 3) == 0);
`else
         bad = 1'b0;
`endif
         send_frame(16'(n), wq, bad, "random");
         expect_state(!bad, bad, "random");
         do_reset();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/boot_loader.md
BOOT_LOADER -- requirements
Module: boot_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 1024, largest accepted image size in 32-bit words.
REQ-002 Parameter: BASE_ADDR, default 32'h8000_0000, memory address of image word 0.
REQ-003 Port: clk  input  1  clock; rising edge only.
REQ-004 Port: rst  input  1  reset, synchronous, active-high.
REQ-005 Port: rx_valid  input  1  byte-stream valid.
REQ-006 Port: rx_data  input  8  byte-stream data.
REQ-007 Port: rx_ready  output  1  byte accepted when rx_valid && rx_ready at clk edge.
REQ-008 Port: cpu_adres  input  32  CPU memory address.
REQ-009 Port: cpu_yaz_veri  input  32  CPU write data.
REQ-010 Port: cpu_yaz  input  1  CPU write strobe.
REQ-011 Port: cpu_rst  output  1  reset to CPU; high until image loaded.
REQ-012 Port: mem_adres  output  32  memory address.
REQ-013 Port: mem_yaz_veri  output  32  memory write data.
REQ-014 Port: mem_yaz  output  1  memory write strobe.
REQ-015 Port: load_done  output  1  image loaded, CPU running.
REQ-016 Port: err  output  1  protocol/length/checksum error.

Function
REQ-017 Frame format SHALL be: sync byte 0xA5, count N (2 bytes, little-endian), 4N payload bytes (each word little-endian), then checksum byte when LOADER_CHECKSUM_EN is defined.
REQ-018 States SHALL be IDLE, LEN0, LEN1, DATA, WRITE, CHECK, RUN, ERROR.
REQ-019 IDLE: accepted 0xA5 -> LEN0; any other accepted byte discarded, stay IDLE.
REQ-020 LEN0 -> LEN1 on accepted byte (low count byte); LEN1 -> DATA on accepted byte, except N==0 or N>MAX_WORDS -> ERROR.
REQ-021 DATA SHALL shift bytes into a word register, byte 0 into bits [7:0]; 4th byte -> WRITE.
REQ-022 WRITE SHALL last exactly one cycle: mem_yaz=1, mem_adres=BASE_ADDR+4*idx, mem_yaz_veri=assembled word; then idx increments; idx==N -> CHECK (or RUN without checksum), else DATA.
REQ-023 rx_ready SHALL be 1 in IDLE, LEN0, LEN1, DATA, CHECK, ERROR; 0 in WRITE and RUN.
REQ-024 Outside WRITE and RUN, mem_yaz SHALL be 0 and mem_adres/mem_yaz_veri hold last WRITE values.
REQ-025 RUN: mem_adres, mem_yaz_veri, mem_yaz SHALL equal cpu_adres, cpu_yaz_veri, cpu_yaz combinationally; cpu_rst=0; load_done=1.
REQ-026 cpu_rst SHALL be 1 in every state except RUN; cpu_yaz SHALL be ignored outside RUN.
REQ-027 RUN SHALL persist until rst; rx_valid in RUN SHALL be ignored.
REQ-028 ERROR: err=1; accepted 0xA5 -> LEN0 with err cleared, idx and checksum cleared; other bytes discarded.
REQ-029 A new 0xA5 in LEN0/LEN1/DATA SHALL be treated as data, not resync.
REQ-030 rx_valid low mid-frame SHALL stall state without timeout.

Reset
REQ-031 On clk edge with rst=1: state IDLE, idx 0, word and checksum registers 0, mem_adres/mem_yaz_veri 0.
REQ-032 After reset: cpu_rst=1, mem_yaz=0, load_done=0, err=0, rx_ready=1.
REQ-033 rst mid-load or in RUN SHALL abandon the frame and re-hold the CPU; already-written memory is not cleared.

Configuration
REQ-034 Macro LOADER_CHECKSUM_EN defined: after last WRITE go CHECK; accepted byte equal to XOR of all 4N payload bytes -> RUN, else -> ERROR.
REQ-035 LOADER_CHECKSUM_EN undefined: no CHECK state or checksum logic; last WRITE -> RUN directly.

Verification
REQ-036 Frame A5 01 00 13 05 10 00 [chk 0x06] -> one write 0x00100513 @0x80000000; RUN, cpu_rst=0, load_done=1.
REQ-037 Frame N=2, words 0x11223344, 0xAABBCCDD, rx_valid toggled every other cycle -> writes @0x80000000, 0x80000004; rx_ready=0 exactly in each WRITE cycle.
REQ-038 Leading bytes 00 FF then valid frame -> garbage discarded, load completes normally.
REQ-039 Count 00 00, and count MAX_WORDS+1 -> ERROR, err=1, no mem_yaz; next A5 01 00 ... loads cleanly.
REQ-040 With LOADER_CHECKSUM_EN, wrong checksum 0x07 on REQ-036 frame -> ERROR, cpu_rst stays 1.
REQ-041 In RUN, cpu_adres=0x80000010, cpu_yaz=1, cpu_yaz_veri=0xDEADBEEF -> same on mem_* same cycle; rst pulse -> cpu_rst=1, load_done=0, state IDLE.
